// File: rtl/frame_dump_trig_if.sv
// frame_dump_trig_if: sync inputs and frame/dump-window outputs of frame_dump_trig
interface frame_dump_trig_if #(parameter int CW = 32);
   logic          vs;
   logic          downloading;
   logic [CW-1:0] frame_cnt;
   logic          frame_stb;
   logic          dump_on;
   logic          dump_start;
   logic          dump_stop;
   logic [1:0]    st;
   modport master (output vs, downloading,
                   input frame_cnt, frame_stb, dump_on, dump_start, dump_stop, st);
   modport slave  (input vs, downloading,
                   output frame_cnt, frame_stb, dump_on, dump_start, dump_stop, st);
endinterface

// File: rtl/frame_dump_trig.sv
// frame_dump_trig: counts VS frames since download end and opens a dump window between two frame numbers
module frame_dump_trig #(
   parameter int CW          = 32,
   parameter int START_FRAME = 0,
   parameter int STOP_FRAME  = 0,
   parameter int WAIT_DL     = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   frame_dump_trig_if.slave   b
);
   typedef enum logic [1:0] {S_WAIT, S_ARMED, S_DUMP, S_DONE} st_t;
   localparam st_t           ST_RST  = (WAIT_DL != 0) ? S_WAIT : S_ARMED;
   localparam logic [CW-1:0] START_V = CW'(START_FRAME);
   localparam logic [CW-1:0] STOP_V  = CW'(STOP_FRAME);
   localparam bit            CLOSE   = (STOP_FRAME != 0) && (STOP_FRAME > START_FRAME);
   logic [2:0]    vs_sync_q, vs_sync_d, dl_sync_q, dl_sync_d;
   logic [CW-1:0] frame_cnt_q, frame_cnt_d, nxt;
   logic          frame_stb_q, frame_stb_d;
   logic          dump_on_q, dump_on_d;
   logic          dump_start_q, dump_start_d;
   logic          dump_stop_q, dump_stop_d;
   st_t           st_q, st_d;
   logic          vs_fall, dl_fall, dl_rise;
   assign vs_fall = vs_sync_q[2] & ~vs_sync_q[1];
   assign dl_fall = dl_sync_q[2] & ~dl_sync_q[1];
   assign dl_rise = ~dl_sync_q[2] & dl_sync_q[1];
   assign b.frame_cnt  = frame_cnt_q;
   assign b.frame_stb  = frame_stb_q;
   assign b.dump_on    = dump_on_q;
   assign b.dump_start = dump_start_q;
   assign b.dump_stop  = dump_stop_q;
   assign b.st         = st_q;
   // next-state: synchronizer shift, frame counting, window FSM and its edge pulses
   always_comb begin
      vs_sync_d   = {vs_sync_q[1:0], b.vs};
      dl_sync_d   = {dl_sync_q[1:0], b.downloading};
      nxt         = frame_cnt_q + CW'(1);
      frame_cnt_d = dl_fall ? '0 : (vs_fall ? nxt : frame_cnt_q);
      frame_stb_d = vs_fall;
      st_d        = st_q;
      if (dl_rise) st_d = ST_RST;
      else begin
         case (st_q)
            S_WAIT:  if (dl_fall) st_d = S_ARMED;
            S_ARMED: if (START_FRAME == 0 || (vs_fall && nxt == START_V)) st_d = S_DUMP;
            S_DUMP:  if (CLOSE && vs_fall && nxt == STOP_V) st_d = S_DONE;
            default: st_d = st_q;
         endcase
      end
      dump_on_d    = st_d == S_DUMP;
      dump_start_d = st_d == S_DUMP && st_q != S_DUMP;
      dump_stop_d  = st_q == S_DUMP && st_d != S_DUMP;
   end
   // state register; reset clears everything immediately without a stop pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_sync_q    <= '0;
         dl_sync_q    <= '0;
         frame_cnt_q  <= '0;
         frame_stb_q  <= 1'b0;
         dump_on_q    <= 1'b0;
         dump_start_q <= 1'b0;
         dump_stop_q  <= 1'b0;
         st_q         <= ST_RST;
      end else begin
         vs_sync_q    <= vs_sync_d;
         dl_sync_q    <= dl_sync_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_stb_q  <= frame_stb_d;
         dump_on_q    <= dump_on_d;
         dump_start_q <= dump_start_d;
         dump_stop_q  <= dump_stop_d;
         st_q         <= st_d;
      end
   end
endmodule

// File: tb/tb_frame_dump_trig.sv
// tb_frame_dump_trig: scoreboard bench for two frame_dump_trig configurations
module tb_frame_dump_trig;
   typedef struct {
      logic [31:0] cnt;
      logic        start;
      logic        stop;
      logic        on;
      logic [1:0]  st;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;
   int   stb_b = 0;
   bit   watch_b = 1'b0;
   bit   drop_b = 1'b0;
   exp_t qa[$];
   exp_t qb[$];
   frame_dump_trig_if #(.CW(32)) ia ();
   frame_dump_trig_if #(.CW(4))  ib ();
   frame_dump_trig #(.CW(32), .START_FRAME(3), .STOP_FRAME(6), .WAIT_DL(1)) u_a (
      .clk(clk), .rst_n(rst_n), .b(ia.slave));
   frame_dump_trig #(.CW(4), .START_FRAME(0), .STOP_FRAME(0), .WAIT_DL(0)) u_b (
      .clk(clk), .rst_n(rst_n), .b(ib.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // scoreboard for unit A: each frame_stb pops one expected record
   always @(negedge clk) begin
      if (rst_n && ia.frame_stb) begin
         if (qa.size() == 0) chk("a_unexpected_stb", 1, 0);
         else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_cnt", ia.frame_cnt, e.cnt);
            chk("a_start", 32'(ia.dump_start), 32'(e.start));
            chk("a_stop", 32'(ia.dump_stop), 32'(e.stop));
            chk("a_on", 32'(ia.dump_on), 32'(e.on));
            chk("a_st", 32'(ia.st), 32'(e.st));
         end
      end
   end
   // scoreboard for unit B plus pulse-width and window-hold watchers
   always @(negedge clk) begin
      if (rst_n && ib.frame_stb) begin
         stb_b++;
         if (qb.size() == 0) chk("b_unexpected_stb", 1, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_cnt", 32'(ib.frame_cnt), e.cnt);
            chk("b_on", 32'(ib.dump_on), 32'(e.on));
            chk("b_st", 32'(ib.st), 32'(e.st));
         end
      end
      if (watch_b && !ib.dump_on) drop_b = 1'b1;
   end
   task automatic frame_a(input logic [31:0] c, input logic s0, input logic s1,
                          input logic on, input logic [1:0] st);
      qa.push_back('{c, s0, s1, on, st});
      ia.vs = 1'b1;
      repeat (4) @(negedge clk);
      ia.vs = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic frame_b(input logic [31:0] c);
      qb.push_back('{c, 1'b0, 1'b0, 1'b1, 2'd2});
      ib.vs = 1'b1;
      repeat (4) @(negedge clk);
      ib.vs = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic wait_stop_a(input string tag);
      int k;
      k = 0;
      while (!ia.dump_stop && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(ia.dump_stop), 1);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      ia.vs = 1'b0;
      ia.downloading = 1'b1;
      ib.vs = 1'b0;
      ib.downloading = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a_st", 32'(ia.st), 0);
      chk("rst_a_cnt", ia.frame_cnt, 0);
      chk("rst_a_on", 32'(ia.dump_on), 0);
      chk("rst_b_st", 32'(ib.st), 1);
      chk("rst_b_outs", {ib.frame_cnt, ib.frame_stb, ib.dump_on, ib.dump_start, ib.dump_stop}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("b_arm_start", 32'(ib.dump_start), 1);
      chk("b_arm_on", 32'(ib.dump_on), 1);
      chk("b_arm_st", 32'(ib.st), 2);
      @(negedge clk);
      chk("b_start_once", 32'(ib.dump_start), 0);
      watch_b = 1'b1;
      for (int i = 1; i <= 16; i++) frame_b(32'(i % 16));
      watch_b = 1'b0;
      chk("b_stb_cycles", 32'(stb_b), 16);
      chk("b_on_held", 32'(drop_b), 0);
      chk("b_q_empty", 32'(qb.size()), 0);
      chk("a_wait_st", 32'(ia.st), 0);
      ia.downloading = 1'b0;
      repeat (5) @(negedge clk);
      chk("a_arm_st", 32'(ia.st), 1);
      chk("a_arm_cnt", ia.frame_cnt, 0);
      qa.push_back('{32'd1, 1'b0, 1'b0, 1'b0, 2'd1});
      ia.vs = 1'b1;
      repeat (4) @(negedge clk);
      ia.vs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("lat_k1", 32'(ia.frame_stb), 0);
      @(negedge clk);
      chk("lat_k2", 32'(ia.frame_stb), 1);
      repeat (2) @(negedge clk);
      for (int i = 2; i <= 7; i++)
         frame_a(32'(i), i == 3, i == 6, i >= 3 && i < 6, i >= 6 ? 2'd3 : (i >= 3 ? 2'd2 : 2'd1));
      chk("a_done_st", 32'(ia.st), 3);
      chk("a_done_on", 32'(ia.dump_on), 0);
      ia.downloading = 1'b1;
      repeat (5) @(negedge clk);
      chk("a_rewait_st", 32'(ia.st), 0);
      ia.downloading = 1'b0;
      repeat (5) @(negedge clk);
      chk("a_rearm_cnt", ia.frame_cnt, 0);
      for (int i = 1; i <= 4; i++) frame_a(32'(i), i == 3, 1'b0, i >= 3, i >= 3 ? 2'd2 : 2'd1);
      ia.downloading = 1'b1;
      wait_stop_a("rise_stop_seen");
      chk("rise_on", 32'(ia.dump_on), 0);
      chk("rise_st", 32'(ia.st), 0);
      chk("rise_cnt", ia.frame_cnt, 4);
      @(negedge clk);
      chk("rise_stop_once", 32'(ia.dump_stop), 0);
      ia.downloading = 1'b0;
      repeat (5) @(negedge clk);
      chk("refall_cnt", ia.frame_cnt, 0);
      chk("refall_st", 32'(ia.st), 1);
      for (int i = 1; i <= 3; i++) frame_a(32'(i), i == 3, 1'b0, i == 3, i == 3 ? 2'd2 : 2'd1);
      ia.downloading = 1'b1;
      wait_stop_a("rise2_stop_seen");
      repeat (2) @(negedge clk);
      qa.push_back('{32'd0, 1'b0, 1'b0, 1'b0, 2'd1});
      ia.vs = 1'b1;
      repeat (4) @(negedge clk);
      ia.vs = 1'b0;
      ia.downloading = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 3; i++) frame_a(32'(i), i == 3, 1'b0, i == 3, i == 3 ? 2'd2 : 2'd1);
      chk("a_q_empty", 32'(qa.size()), 0);
      chk("pre_rst_on", 32'(ia.dump_on), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outs", {ia.frame_cnt[29:0], ia.frame_stb, ia.dump_on}, 0);
      chk("arst_pulses", {ia.dump_start, ia.dump_stop}, 0);
      chk("arst_st", 32'(ia.st), 0);
      chk("arst_b_st", 32'(ib.st), 1);
      repeat (3) @(negedge clk);
      chk("arst_no_stop", 32'(ia.dump_stop), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
